// File: rtl/pattern_pixel_source.sv
// Test-pattern pixel source that scans an X_SIZE x Y_SIZE frame with sof/eol markers.
// Supported modes are solid, colour bars, gradient and checker. Config is latched once per frame.
module pattern_pixel_source #(
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int CHECK_SHIFT = 5,
  parameter int FC_W        = 16
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [23:0]     solid_rgb,
  input  logic            ready,
  output logic            valid,
  output logic [7:0]      r,
  output logic [7:0]      g,
  output logic [7:0]      b,
  output logic            sof,
  output logic            eol,
  output logic [FC_W-1:0] frame_count,
  output logic            busy
);

  localparam int XW  = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW  = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int BW  = X_SIZE / 8;
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(X_SIZE - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(Y_SIZE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BW - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [BCW-1:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [1:0]      mode_q, mode_d;
  logic [23:0]     rgb_q, rgb_d;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    fc_d      = fc_q;
    mode_d    = mode_q;
    rgb_d     = rgb_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_RUN;
          mode_d    = mode;
          rgb_d     = solid_rgb;
          x_d       = '0;
          y_d       = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
        end
      end
      default: begin
        if (ready) begin
          if (x_q == X_LAST) begin
            x_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
            if (y_q == Y_LAST) begin
              // Frame boundary: the only point where config may change.
              y_d  = '0;
              fc_d = fc_q + 1'b1;
              if (enable) begin
                mode_d = mode;
                rgb_d  = solid_rgb;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
            if (bar_cnt_q == BC_LAST) begin
              bar_cnt_d = '0;
              bar_idx_d = bar_idx_q + 1'b1;
            end else begin
              bar_cnt_d = bar_cnt_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      fc_q      <= '0;
      mode_q    <= '0;
      rgb_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      fc_q      <= fc_d;
      mode_q    <= mode_d;
      rgb_q     <= rgb_d;
    end
  end

  logic        run;
  logic        sel;
  logic [23:0] pix;

  assign run = (state_q == S_RUN);
  // A checker bit beyond the counter width is zero, so the mask form needs no range guard.
  assign sel = (|(x_q & (XW'(1) << CHECK_SHIFT))) ^ (|(y_q & (YW'(1) << CHECK_SHIFT)));

  always_comb begin
    pix = '0;
    case (mode_q)
      2'd0:    pix = rgb_q;
      2'd1:    pix = {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
      2'd2:    pix = {8'(x_q), 8'(y_q), 8'(fc_q)};
      default: pix = sel ? ~rgb_q : rgb_q;
    endcase
  end

  assign valid       = run;
  assign busy        = run;
  assign sof         = run && (x_q == '0) && (y_q == '0);
  assign eol         = run && (x_q == X_LAST);
  assign {r, g, b}   = run ? pix : 24'h0;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_pattern_pixel_source.sv
// Randomised bench for pattern_pixel_source against a beat-index reference model.
module tb_pattern_pixel_source;

  localparam int XS = 16;
  localparam int YS = 4;
  localparam int CS = 2;
  localparam int FW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [23:0]   solid_rgb = 24'h0;
  logic          ready = 1'b0;
  logic          valid, sof, eol, busy;
  logic [7:0]    r, g, b;
  logic [FW-1:0] frame_count;

  pattern_pixel_source #(.X_SIZE(XS), .Y_SIZE(YS), .CHECK_SHIFT(CS), .FC_W(FW)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .ready(ready), .valid(valid), .r(r), .g(g), .b(b), .sof(sof), .eol(eol),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  // Model: pixel position is derived from a flat beat index within the frame.
  bit          m_run = 0;
  int          m_beat = 0;
  int          m_frames = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [23:0] m_rgb = 24'h0;
  bit          prev_stall = 0;
  logic [25:0] prev_out = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_pix(int beat, int frames, logic [1:0] md, logic [23:0] c);
    int x = beat % XS;
    int y = beat / XS;
    int idx = x / (XS / 8);
    int fc = frames % (1 << FW);
    logic [7:0] rr, gg, bb;
    case (md)
      2'd0: return c;
      2'd1: begin
        rr = (idx == 0 || idx == 1 || idx == 4 || idx == 5) ? 8'hFF : 8'h00;
        gg = (idx < 4) ? 8'hFF : 8'h00;
        bb = (idx % 2 == 0) ? 8'hFF : 8'h00;
        return {rr, gg, bb};
      end
      2'd2: return {8'(x % 256), 8'(y % 256), 8'(fc % 256)};
      default: return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? ~c : c;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_beat = 0; m_frames = 0; m_mode = 2'd0; m_rgb = 24'h0; prev_stall = 0;
  endtask

  task automatic check_outputs();
    chk("valid", 32'(valid), 32'(m_run));
    chk("busy", 32'(busy), 32'(m_run));
    chk("frame_count", 32'(frame_count), 32'(m_frames % (1 << FW)));
    if (m_run) begin
      chk("rgb", {8'h0, r, g, b}, {8'h0, exp_pix(m_beat, m_frames, m_mode, m_rgb)});
      chk("sof", 32'(sof), 32'(m_beat == 0));
      chk("eol", 32'(eol), 32'(m_beat % XS == XS - 1));
    end else begin
      chk("idle_out", {6'h0, r, g, b, sof, eol}, 32'h0);
    end
    if (prev_stall) chk("stable", {6'h0, r, g, b, sof, eol}, {6'h0, prev_out});
    prev_out = {r, g, b, sof, eol};
  endtask

  task automatic model_step(input bit en, input logic [1:0] md, input logic [23:0] c, input bit rdy);
    prev_stall = m_run && !rdy;
    if (!aresetn) begin
      model_reset();
    end else if (!m_run) begin
      if (en) begin m_run = 1; m_beat = 0; m_mode = md; m_rgb = c; end
    end else if (rdy) begin
      if (m_beat == XS * YS - 1) begin
        m_beat = 0;
        m_frames++;
        if (en) begin m_mode = md; m_rgb = c; end
        else m_run = 0;
      end else begin
        m_beat++;
      end
    end
  endtask

  // Called at a negedge: check, drive inputs for the next posedge, advance the model.
  task automatic cycle(input bit en, input logic [1:0] md, input logic [23:0] c, input bit rdy);
    check_outputs();
    enable = en; mode = md; solid_rgb = c; ready = rdy;
    model_step(en, md, c, rdy);
    @(negedge aclk);
  endtask

  initial begin
    int guard;
    @(negedge aclk);
    repeat (3) cycle(1'b1, 2'd0, 24'h123456, 1'b1);
    cycle(1'b0, 2'd0, 24'h0, 1'b1);
    aresetn = 1'b1;

    // Solid colour, continuous ready, back-to-back frames.
    repeat (140) cycle(1'b1, 2'd0, 24'h123456, 1'b1);
    // Colour bars; rgb input wiggles but bars ignore it.
    repeat (80) cycle(1'b1, 2'd1, 24'($urandom), 1'b1);
    // Random ready with mode/colour changing every cycle; only frame-boundary values matter.
    repeat (400) cycle(1'b1, 2'($urandom_range(0, 3)), 24'($urandom), $urandom_range(0, 9) >= 3);
    // Gradient long enough to wrap the frame counter, then checker mid-frame switch.
    repeat (1100) cycle(1'b1, 2'd2, 24'h0, 1'b1);
    repeat (150) cycle(1'b1, 2'd3, 24'h0F33C5, $urandom_range(0, 9) >= 3);

    // Drop enable at beat 10 of a frame; the frame must still complete.
    guard = 0;
    while (!(m_run && m_beat == 10) && guard < 300) begin
      cycle(1'b1, 2'd1, 24'h0, 1'b1);
      guard++;
    end
    if (guard >= 300) chk("timeout_beat10", 32'd0, 32'd1);
    repeat (90) cycle(1'b0, 2'd1, 24'h0, $urandom_range(0, 9) >= 2);

    // Async reset mid-line, observed with no clock edge in between.
    guard = 0;
    while (!(m_run && m_beat == XS + 5) && guard < 300) begin
      cycle(1'b1, 2'd2, 24'h0, 1'b1);
      guard++;
    end
    if (guard >= 300) chk("timeout_midline", 32'd0, 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    model_reset();
    @(negedge aclk);
    cycle(1'b1, 2'd0, 24'hA5A5A5, 1'b1);
    aresetn = 1'b1;
    repeat (100) cycle(1'b1, 2'd0, 24'hA5A5A5, 1'b1);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
